edge_enh_frame_ctrl: RTL and testbench
======================================

EDGE_ENH_FRAME_CTRL -- requirements
Module: edge_enh_frame_ctrl

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 4096, meaning the maximum pixels per line and the line-buffer depth.
REQ-002 SHALL have parameter MAX_HEIGHT, default 4096, meaning the maximum lines per frame.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  in  1  clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 cfg_width_i  in  13  pixels per line, legal range 1..MAX_WIDTH.
REQ-007 cfg_height_i  in  13  lines per frame, legal range 1..MAX_HEIGHT.
REQ-008 cfg_enable_i  in  1  sharpening enable.
REQ-009 cfg_strength_i  in  8  sharpening strength.
REQ-010 in_valid_i  in  1  input pixel valid.
REQ-011 in_sof_i  in  1  start of frame; qualified by in_valid_i.
REQ-012 in_ready_o  out  1  pixel accept; accept = in_valid_i & in_ready_o.
REQ-013 lb_wr_en_o  out  1  line-buffer write strobe, combinational, equal to accept outside IDLE or on an SOF accept.
REQ-014 lb_wr_addr_o  out  12  write column; equals the current column count.
REQ-015 lb_wr_sel_o  out  2  line buffer being written (0..2).
REQ-016 win_valid_o  out  1  3x3 window centre is valid this cycle.
REQ-017 win_x_o, win_y_o  out  13 each  window centre coordinates.
REQ-018 border_o  out  1  centre lies on the frame edge.
REQ-019 act_enable_o, act_strength_o  out  1/8  shadowed configuration for the current frame.
REQ-020 busy_o  out  1  asserted whenever the state is not IDLE.
REQ-021 frame_done_o  out  1  one-cycle pulse at frame end.
REQ-022 err_o  out  1  one-cycle pulse on a protocol or configuration error.

Function
REQ-023 SHALL implement the states IDLE, FILL, ACTIVE, DRAIN and DONE.
REQ-024 in_ready_o SHALL be 1 in IDLE, FILL and ACTIVE, and 0 in DRAIN and DONE.
REQ-025 In IDLE, an accept with in_sof_i=1 and legal width and height SHALL:
  - latch width, height, enable and strength into shadow registers;
  - treat the pixel as column 0 of row 0;
  - set lb_wr_sel_o to 0;
  - go to FILL.
REQ-026 In IDLE, an accept without in_sof_i SHALL be discarded with no write, no window and no error.
REQ-027 In IDLE, an SOF accept with width 0, width > MAX_WIDTH, height 0 or height > MAX_HEIGHT SHALL be ignored, pulse err_o, and remain in IDLE.
REQ-028 On each accepted pixel, the column SHALL increment; at width-1 it SHALL wrap to 0, increment the row, and rotate lb_wr_sel_o 0->1->2->0.
REQ-029 FILL covers input row 0, with no window output; at the end of row 0 the state SHALL go to ACTIVE if height > 1, else to DRAIN.
REQ-030 In ACTIVE, an accept at (x, r) SHALL produce, one cycle later, win_valid_o=1 with win_x_o=x and win_y_o=r-1.
REQ-031 At the end of row height-1, the state SHALL go to DRAIN.
REQ-032 DRAIN SHALL emit exactly width windows at win_y_o=height-1, with win_x_o running 0..width-1, one per cycle, starting the cycle after entry; it SHALL then go to DONE.
REQ-033 DONE SHALL assert frame_done_o for one cycle and then go to IDLE.
REQ-034 border_o SHALL be registered alongside win_valid_o and equal (x==0 | x==width-1 | y==0 | y==height-1); it SHALL be 0 whenever win_valid_o=0.
REQ-035 An SOF accept in FILL or ACTIVE SHALL:
  - pulse err_o;
  - abandon the frame with no further windows for it;
  - restart exactly as in REQ-025 (including the legality check; if illegal, go to IDLE).
REQ-036 in_sof_i SHALL be ignored while in_ready_o=0.
REQ-037 Changes on cfg_* ports SHALL affect only the shadow registers at the next SOF accept.
REQ-038 win_valid_o SHALL be high exactly width*height times per completed frame.

Reset
REQ-039 With rst_i=1 at a clock edge, all of the following SHALL take their reset values on the next cycle, regardless of state (including DRAIN), with no frame_done_o pulse:
  - state = IDLE;
  - counters = 0, lb_wr_sel_o = 0;
  - win_valid_o, border_o, frame_done_o, err_o, busy_o = 0;
  - act_enable_o = 0, act_strength_o = 0;
  - in_ready_o = 1.

Verification
REQ-040 W=4, H=3 frame, continuous valid -> 12 accepts; 12 win_valid_o pulses (y=0 during row 1, y=1 during row 2, y=2 during 4 DRAIN cycles); border_o on 10 of them, 0 only at (1,1) and (2,1); one frame_done_o.
REQ-041 W=3, H=1 -> FILL then DRAIN; 3 windows at y=0, all with border_o=1; in_ready_o=0 for 4 cycles (3 DRAIN, 1 DONE).
REQ-042 W=4, H=3, SOF at row 1 col 2 -> err_o pulses once; lb_wr_sel_o=0, lb_wr_addr_o=0; a full 12-window frame follows.
REQ-043 SOF with cfg_width_i=0 -> err_o pulses, busy_o stays 0, no writes; the next legal SOF starts normally.
REQ-044 cfg_strength_i changed 0x10->0x40 mid-frame -> act_strength_o stays 0x10 until the next SOF accept.
REQ-045 rst_i asserted in the 2nd DRAIN cycle -> next cycle state IDLE, win_valid_o=0, busy_o=0, no frame_done_o.

Source files
------------

// File: rtl/edge_enh_frame_ctrl.sv
// rtl/edge_enh_frame_ctrl.sv - frame/line sequencer for a 3x3 edge-enhancement window
// Tracks pixel position, line-buffer rotation and window-centre emission per frame.
module edge_enh_frame_ctrl #(
  parameter int MAX_WIDTH  = 4096,
  parameter int MAX_HEIGHT = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [12:0] cfg_width_i,
  input  logic [12:0] cfg_height_i,
  input  logic        cfg_enable_i,
  input  logic [7:0]  cfg_strength_i,
  input  logic        in_valid_i,
  input  logic        in_sof_i,
  output logic        in_ready_o,
  output logic        lb_wr_en_o,
  output logic [11:0] lb_wr_addr_o,
  output logic [1:0]  lb_wr_sel_o,
  output logic        win_valid_o,
  output logic [12:0] win_x_o,
  output logic [12:0] win_y_o,
  output logic        border_o,
  output logic        act_enable_o,
  output logic [7:0]  act_strength_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [12:0] MAX_W = 13'(MAX_WIDTH);
  localparam logic [12:0] MAX_H = 13'(MAX_HEIGHT);

  state_t      state_q, state_d;
  logic [12:0] col_q, col_d;
  logic [12:0] row_q, row_d;
  logic [1:0]  sel_q, sel_d;
  logic [12:0] dx_q, dx_d;
  logic [12:0] w_q, w_d;
  logic [12:0] h_q, h_d;
  logic        en_q, en_d;
  logic [7:0]  str_q, str_d;
  logic        win_valid_q, win_valid_d;
  logic [12:0] win_x_q, win_x_d;
  logic [12:0] win_y_q, win_y_d;
  logic        border_q, border_d;
  logic        err_q, err_d;

  logic        accept;
  logic        sof_acc;
  logic        cfg_legal;
  logic        last_col;
  logic        last_row;
  logic        wv;
  logic [12:0] wx;
  logic [12:0] wy;

  assign in_ready_o = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_ACTIVE);
  assign accept     = in_valid_i & in_ready_o;
  assign sof_acc    = accept & in_sof_i;
  assign cfg_legal  = (cfg_width_i != 13'd0) && (cfg_width_i <= MAX_W) &&
                      (cfg_height_i != 13'd0) && (cfg_height_i <= MAX_H);
  assign last_col   = (col_q == w_q - 13'd1);
  assign last_row   = (row_q == h_q - 13'd1);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    sel_d     = sel_q;
    dx_d      = dx_q;
    w_d       = w_q;
    h_d       = h_q;
    en_d      = en_q;
    str_d     = str_q;
    err_d     = 1'b0;
    wv        = 1'b0;
    wx        = win_x_q;
    wy        = win_y_q;

    if (sof_acc) begin
      // An SOF outside IDLE abandons the running frame before any restart.
      err_d = (state_q != S_IDLE) || !cfg_legal;
      if (cfg_legal) begin
        w_d   = cfg_width_i;
        h_d   = cfg_height_i;
        en_d  = cfg_enable_i;
        str_d = cfg_strength_i;
        dx_d  = 13'd0;
        if (cfg_width_i == 13'd1) begin
          col_d   = 13'd0;
          row_d   = 13'd1;
          sel_d   = 2'd1;
          state_d = (cfg_height_i == 13'd1) ? S_DRAIN : S_ACTIVE;
        end else begin
          col_d   = 13'd1;
          row_d   = 13'd0;
          sel_d   = 2'd0;
          state_d = S_FILL;
        end
      end else begin
        col_d   = 13'd0;
        row_d   = 13'd0;
        sel_d   = 2'd0;
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_FILL, S_ACTIVE: begin
          if (accept) begin
            if (state_q == S_ACTIVE) begin
              wv = 1'b1;
              wx = col_q;
              wy = row_q - 13'd1;
            end
            if (last_col) begin
              col_d = 13'd0;
              row_d = row_q + 13'd1;
              sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
              if (last_row) begin
                state_d = S_DRAIN;
                dx_d    = 13'd0;
              end else begin
                state_d = S_ACTIVE;
              end
            end else begin
              col_d = col_q + 13'd1;
            end
          end
        end
        S_DRAIN: begin
          // Bottom row has no line below it; emit it from the buffers alone.
          wv = 1'b1;
          wx = dx_q;
          wy = h_q - 13'd1;
          if (dx_q == w_q - 13'd1) begin
            state_d = S_DONE;
          end else begin
            dx_d = dx_q + 13'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          col_d   = 13'd0;
          row_d   = 13'd0;
          sel_d   = 2'd0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    win_valid_d = wv;
    win_x_d     = wx;
    win_y_d     = wy;
    border_d    = wv && ((wx == 13'd0) || (wx == w_q - 13'd1) ||
                         (wy == 13'd0) || (wy == h_q - 13'd1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      col_q       <= 13'd0;
      row_q       <= 13'd0;
      sel_q       <= 2'd0;
      dx_q        <= 13'd0;
      w_q         <= 13'd0;
      h_q         <= 13'd0;
      en_q        <= 1'b0;
      str_q       <= 8'd0;
      win_valid_q <= 1'b0;
      win_x_q     <= 13'd0;
      win_y_q     <= 13'd0;
      border_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sel_q       <= sel_d;
      dx_q        <= dx_d;
      w_q         <= w_d;
      h_q         <= h_d;
      en_q        <= en_d;
      str_q       <= str_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      border_q    <= border_d;
      err_q       <= err_d;
    end
  end

  assign lb_wr_en_o     = accept & ((state_q != S_IDLE) | (in_sof_i & cfg_legal));
  assign lb_wr_addr_o   = sof_acc ? 12'd0 : col_q[11:0];
  assign lb_wr_sel_o    = sof_acc ? 2'd0 : sel_q;
  assign win_valid_o    = win_valid_q;
  assign win_x_o        = win_x_q;
  assign win_y_o        = win_y_q;
  assign border_o       = border_q;
  assign act_enable_o   = en_q;
  assign act_strength_o = str_q;
  assign busy_o         = (state_q != S_IDLE);
  assign frame_done_o   = (state_q == S_DONE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_edge_enh_frame_ctrl.sv
// tb/tb_edge_enh_frame_ctrl.sv - scoreboard bench for edge_enh_frame_ctrl
module tb_edge_enh_frame_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [12:0] cfg_width_i, cfg_height_i;
  logic        cfg_enable_i;
  logic [7:0]  cfg_strength_i;
  logic        in_valid_i, in_sof_i;
  logic        in_ready_o, lb_wr_en_o;
  logic [11:0] lb_wr_addr_o;
  logic [1:0]  lb_wr_sel_o;
  logic        win_valid_o;
  logic [12:0] win_x_o, win_y_o;
  logic        border_o, act_enable_o;
  logic [7:0]  act_strength_o;
  logic        busy_o, frame_done_o, err_o;

  edge_enh_frame_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
    .cfg_enable_i(cfg_enable_i), .cfg_strength_i(cfg_strength_i),
    .in_valid_i(in_valid_i), .in_sof_i(in_sof_i), .in_ready_o(in_ready_o),
    .lb_wr_en_o(lb_wr_en_o), .lb_wr_addr_o(lb_wr_addr_o), .lb_wr_sel_o(lb_wr_sel_o),
    .win_valid_o(win_valid_o), .win_x_o(win_x_o), .win_y_o(win_y_o),
    .border_o(border_o), .act_enable_o(act_enable_o), .act_strength_o(act_strength_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int x;
    int y;
    int b;
  } win_t;

  win_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  int   win_cnt = 0, border_cnt = 0, done_cnt = 0, err_cnt = 0, nr_cnt = 0, busy_cnt = 0;
  int   s_win, s_bord, s_done, s_err, s_nr, s_busy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int bord(input int x, input int y, input int w, input int h);
    return ((x == 0) || (x == w - 1) || (y == 0) || (y == h - 1)) ? 1 : 0;
  endfunction

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (win_valid_o) begin
        win_cnt++;
        if (border_o) border_cnt++;
        if (exp_q.size() == 0) begin
          chk("win_unexpected", win_valid_o, 0);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          chk("win_x", win_x_o, e.x);
          chk("win_y", win_y_o, e.y);
          chk("win_border", border_o, e.b);
        end
      end else begin
        chk("border_without_valid", border_o, 0);
      end
      if (frame_done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (!in_ready_o) nr_cnt++;
      if (busy_o) busy_cnt++;
    end
  end

  task automatic snap();
    s_win = win_cnt; s_bord = border_cnt; s_done = done_cnt;
    s_err = err_cnt; s_nr = nr_cnt; s_busy = busy_cnt;
  endtask

  task automatic pix(input bit sof, input bit exp_wr);
    in_valid_i = 1'b1;
    in_sof_i   = sof;
    #1;
    if (sof) begin
      chk("wr_en_on_sof", lb_wr_en_o, exp_wr);
      if (exp_wr) begin
        chk("wr_addr_on_sof", lb_wr_addr_o, 0);
        chk("wr_sel_on_sof", lb_wr_sel_o, 0);
      end
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    in_sof_i   = 1'b0;
  endtask

  // Drives pixels [from,to) of a w x h frame, queueing the windows each should yield.
  task automatic play(input int w, input int h, input int from, input int to);
    for (int idx = from; idx < to; idx++) begin
      int r, c;
      r = idx / w;
      c = idx % w;
      if (r >= 1) exp_q.push_back('{c, r - 1, bord(c, r - 1, w, h)});
      if (idx == w * h - 1)
        for (int dx = 0; dx < w; dx++) exp_q.push_back('{dx, h - 1, bord(dx, h - 1, w, h)});
      pix(idx == 0, 1'b1);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (!busy_o) break;
    end
    chk("idle_timeout", busy_o, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic set_cfg(input int w, input int h, input bit en, input int s);
    cfg_width_i    = 13'(w);
    cfg_height_i   = 13'(h);
    cfg_enable_i   = en;
    cfg_strength_i = 8'(s);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    in_sof_i = 1'b0;
    set_cfg(4, 3, 1'b0, 0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_win_valid", win_valid_o, 0);
    chk("rst_border", border_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_act_enable", act_enable_o, 0);
    chk("rst_act_strength", act_strength_o, 0);
    chk("rst_wr_sel", lb_wr_sel_o, 0);
    mon_en = 1'b1;

    // Non-SOF pixel in IDLE is dropped silently
    snap();
    in_valid_i = 1'b1;
    #1;
    chk("idle_nosof_wr_en", lb_wr_en_o, 0);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("idle_nosof_busy", busy_cnt - s_busy, 0);
    chk("idle_nosof_err", err_cnt - s_err, 0);

    // 4x3 frame, continuous valid
    set_cfg(4, 3, 1'b1, 8'h22);
    snap();
    play(4, 3, 0, 12);
    wait_idle();
    chk("f43_windows", win_cnt - s_win, 12);
    chk("f43_borders", border_cnt - s_bord, 10);
    chk("f43_done", done_cnt - s_done, 1);
    chk("f43_err", err_cnt - s_err, 0);
    chk("f43_sb_empty", exp_q.size(), 0);
    chk("f43_act_enable", act_enable_o, 1);
    chk("f43_act_strength", act_strength_o, 8'h22);

    // 3x1 frame goes FILL -> DRAIN
    set_cfg(3, 1, 1'b0, 8'h05);
    snap();
    play(3, 1, 0, 3);
    wait_idle();
    chk("f31_not_ready", nr_cnt - s_nr, 4);
    chk("f31_windows", win_cnt - s_win, 3);
    chk("f31_borders", border_cnt - s_bord, 3);
    chk("f31_done", done_cnt - s_done, 1);
    chk("f31_act_enable", act_enable_o, 0);

    // SOF at row 1 col 2 restarts the frame
    set_cfg(4, 3, 1'b1, 8'h11);
    snap();
    play(4, 3, 0, 6);
    play(4, 3, 0, 12);
    wait_idle();
    chk("abort_err", err_cnt - s_err, 1);
    chk("abort_windows", win_cnt - s_win, 14);
    chk("abort_done", done_cnt - s_done, 1);
    chk("abort_sb_empty", exp_q.size(), 0);

    // Illegal width on SOF
    set_cfg(0, 3, 1'b1, 8'h33);
    snap();
    pix(1'b1, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("badcfg_err", err_cnt - s_err, 1);
    chk("badcfg_busy", busy_cnt - s_busy, 0);
    set_cfg(2, 2, 1'b1, 8'h33);
    snap();
    play(2, 2, 0, 4);
    wait_idle();
    chk("after_bad_windows", win_cnt - s_win, 4);
    chk("after_bad_done", done_cnt - s_done, 1);
    chk("after_bad_err", err_cnt - s_err, 0);

    // Strength change mid-frame only lands at the next SOF
    set_cfg(4, 3, 1'b1, 8'h10);
    play(4, 3, 0, 5);
    cfg_strength_i = 8'h40;
    chk("shadow_mid", act_strength_o, 8'h10);
    play(4, 3, 5, 12);
    wait_idle();
    chk("shadow_after", act_strength_o, 8'h10);
    play(4, 3, 0, 1);
    chk("shadow_new_sof", act_strength_o, 8'h40);
    play(4, 3, 1, 12);
    wait_idle();

    // Reset during the second DRAIN cycle
    set_cfg(4, 3, 1'b1, 8'h20);
    snap();
    play(4, 3, 0, 12);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("drain_rst_busy", busy_o, 0);
    chk("drain_rst_win_valid", win_valid_o, 0);
    chk("drain_rst_frame_done", frame_done_o, 0);
    chk("drain_rst_in_ready", in_ready_o, 1);
    chk("drain_rst_act_strength", act_strength_o, 0);
    repeat (4) @(posedge clk_i);
    #1;
    chk("drain_rst_no_done", done_cnt - s_done, 0);
    chk("drain_rst_pending", exp_q.size(), 3);
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
